fir_s2p_buffer: RTL and testbench

- Serial-to-parallel stage between the FIR filter and the FFT in the FAS datapath.
- Collects consecutive 16-bit fir_d samples, qualified by fir_valid, into N-sample frames.
- Presents each complete frame to the FFT as one parallel word over a valid/ready handshake.
- Ping-pong (two-bank) storage: the next frame fills while the FFT holds the current one.

---
 rtl/fas_pkg.sv | 30 +++
 rtl/s2p_bank.sv | 39 +++
 rtl/fir_s2p_buffer.sv | 122 ++++++++++++
 tb/tb_fir_s2p_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fas_pkg.sv
// rtl/fas_pkg.sv - shared FAS datapath constants and slot helpers
package fas_pkg;

  // Default sample width and frame length of the FIR-to-FFT path
  localparam int DW_DEF   = 16;
  localparam int N_DEF    = 16;
  localparam int LOGN_DEF = $clog2(N_DEF);

  // Widest address the bit-reversal helper handles (N up to 256)
  localparam int LOGN_MAX = 8;

  // Reverse the low logn bits of v; bits above logn come back as zero
  function automatic logic [LOGN_MAX-1:0] bitrev(input logic [LOGN_MAX-1:0] v,
                                                 input int logn);
    logic [LOGN_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < LOGN_MAX; i++) begin
      if (i < logn) begin
        r[3'(logn - 1 - i)] = v[3'(i)];
      end
    end
    return r;
  endfunction

  // Bit offset of slot i inside a flat frame word
  function automatic int slot_off(input int slot, input int dw);
    return slot * dw;
  endfunction

endpackage

// File: rtl/s2p_bank.sv
// rtl/s2p_bank.sv - one N x DW sample bank with flat frame read-out
import fas_pkg::*;

module s2p_bank #(
  parameter int DW   = DW_DEF,
  parameter int N    = N_DEF,
  parameter int LOGN = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [LOGN-1:0]   addr,
  input  logic [DW-1:0]     din,
  output logic [N*DW-1:0]   dout
);

  logic [DW-1:0] mem [N];

  // Store one sample verbatim at the addressed slot; reset clears every slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int i = 0; i < N; i++) begin
        if (addr == LOGN'(i)) begin
          mem[i] <= din;
        end
      end
    end
  end

  // Flatten the bank so slot i sits at bits [i*DW +: DW]
  for (genvar g = 0; g < N; g++) begin : g_flat
    assign dout[slot_off(g, DW) +: DW] = mem[g];
  end

endmodule

// File: rtl/fir_s2p_buffer.sv
// rtl/fir_s2p_buffer.sv - ping-pong serial-to-parallel FIR-to-FFT frame buffer (option S2P_BITREV_EN)
import fas_pkg::*;

module fir_s2p_buffer #(
  parameter int DW = DW_DEF,
  parameter int N  = N_DEF   // power of two in {8, 16, 32}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_d,
  input  logic              flush,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [N*DW-1:0]   frame_d,
  output logic [7:0]        frame_cnt,
  output logic              ovf
);

  localparam int LOGN = $clog2(N);

  logic [LOGN-1:0] wr_cnt;
  logic [LOGN-1:0] slot;
  logic            wr_bank;
  logic            rd_bank;
  logic [1:0]      full;
  logic            accept;
  logic            drop;
  logic            last;
  logic            handshake;
  logic [N*DW-1:0] bank0_d;
  logic [N*DW-1:0] bank1_d;

  // The full flag is sampled before the edge, so a bank freed by a handshake
  // in this cycle still refuses a sample arriving in the same cycle.
  assign accept    = in_valid & ~flush & ~full[wr_bank];
  assign drop      = in_valid & ~flush &  full[wr_bank];
  assign last      = accept & (wr_cnt == LOGN'(N - 1));
  assign frame_valid = full[rd_bank];
  assign handshake = frame_valid & frame_ready;
  assign frame_d   = rd_bank ? bank1_d : bank0_d;

`ifdef S2P_BITREV_EN
  // Bit-reversed slot order so a DIT FFT can read the frame directly
  assign slot = LOGN'(bitrev(LOGN_MAX'(wr_cnt), LOGN));
`else
  // Natural slot order
  assign slot = wr_cnt;
`endif

  s2p_bank #(.DW(DW), .N(N), .LOGN(LOGN)) u_bank0 (
    .clk  (clk),
    .rst  (rst),
    .we   (accept & ~wr_bank),
    .addr (slot),
    .din  (in_d),
    .dout (bank0_d)
  );

  s2p_bank #(.DW(DW), .N(N), .LOGN(LOGN)) u_bank1 (
    .clk  (clk),
    .rst  (rst),
    .we   (accept & wr_bank),
    .addr (slot),
    .din  (in_d),
    .dout (bank1_d)
  );

  // Write pointer: advance on accepted samples, hop banks at frame end, flush restarts the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (flush) begin
      wr_cnt  <= '0;
    end else if (accept) begin
      if (last) begin
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_cnt  <= wr_cnt + 1'b1;
      end
    end
  end

  // Full flags: the completing bank and the handshaking bank are always different
  // banks, so set and clear never collide on the same flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (last && (wr_bank == 1'(b))) begin
          full[b] <= 1'b1;
        end else if (handshake && (rd_bank == 1'(b))) begin
          full[b] <= 1'b0;
        end
      end
    end
  end

  // Read pointer and hand-off counter step on each accepted frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank   <= 1'b0;
      frame_cnt <= 8'd0;
    end else if (handshake) begin
      rd_bank   <= ~rd_bank;
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Sticky overflow: any sample refused because its bank was still full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_s2p_buffer.sv
// tb/tb_fir_s2p_buffer.sv - directed self-checking bench for fir_s2p_buffer
module tb_fir_s2p_buffer;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [15:0]  in_d;
  logic         flush;
  logic         frame_valid;
  logic         frame_ready;
  logic [255:0] frame_d;
  logic [7:0]   frame_cnt;
  logic         ovf;

  int vectors;
  int miscompares;

  fir_s2p_buffer #(.DW(16), .N(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_d        (in_d),
    .flush       (flush),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_d     (frame_d),
    .frame_cnt   (frame_cnt),
    .ovf         (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slot that the k-th accepted sample of a frame should land in
  function automatic int map_slot(input int k);
`ifdef S2P_BITREV_EN
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
`else
    return k;
`endif
  endfunction

  // Expected frame word for samples base, base+1, ... base+15
  function automatic logic [255:0] build(input logic [15:0] base);
    logic [255:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) begin
      w = w | (256'(base + 16'(k)) << (map_slot(k) * 16));
    end
    return w;
  endfunction

  function automatic logic [15:0] slot_of(input logic [255:0] w, input int s);
    return 16'(w >> (s * 16));
  endfunction

  // Inputs change at the falling edge; outputs are read there too
  task automatic drive(input logic v, input logic [15:0] d);
    in_valid = v;
    in_d     = d;
    @(negedge clk);
  endtask

  task automatic push_seq(input logic [15:0] base, input int count);
    for (int k = 0; k < count; k++) begin
      drive(1'b1, base + 16'(k));
    end
    in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; in_d = '0; flush = 1'b0; frame_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b want 0", frame_valid); end
    vectors++; if (frame_d !== 256'd0) begin miscompares++; $display("FAIL reset_data: got %h want 0", frame_d); end
    vectors++; if (frame_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
  endtask

  task automatic test_basic();
    apply_reset();
    frame_ready = 1'b1;
    push_seq(16'h0001, 16);
    vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %0b want 1", frame_valid); end
    vectors++; if (frame_d !== build(16'h0001)) begin miscompares++; $display("FAIL basic_data: got %h want %h", frame_d, build(16'h0001)); end
    drive(1'b0, 16'h0000);
    vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL basic_one_cycle: got %0b want 0", frame_valid); end
    vectors++; if (frame_cnt !== 8'd1) begin miscompares++; $display("FAIL basic_cnt: got %0d want 1", frame_cnt); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL basic_ovf: got %0b want 0", ovf); end
    frame_ready = 1'b0;
  endtask

  task automatic test_overflow();
    apply_reset();
    push_seq(16'h0001, 32);
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %0b want 0", ovf); end
    push_seq(16'h0021, 16);
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %0b want 1", ovf); end
    vectors++; if (frame_d !== build(16'h0001)) begin miscompares++; $display("FAIL ovf_hold_data: got %h want %h", frame_d, build(16'h0001)); end
    vectors++; if (frame_cnt !== 8'd0) begin miscompares++; $display("FAIL ovf_no_hs: got %0d want 0", frame_cnt); end
    frame_ready = 1'b1;
    drive(1'b0, 16'h0000);
    vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_second_valid: got %0b want 1", frame_valid); end
    vectors++; if (frame_d !== build(16'h0011)) begin miscompares++; $display("FAIL ovf_second_data: got %h want %h", frame_d, build(16'h0011)); end
    drive(1'b0, 16'h0000);
    frame_ready = 1'b0;
    vectors++; if (frame_cnt !== 8'd2) begin miscompares++; $display("FAIL ovf_cnt: got %0d want 2", frame_cnt); end
    vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_drained: got %0b want 0", frame_valid); end
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %0b want 1", ovf); end
  endtask

  task automatic test_flush();
    apply_reset();
    push_seq(16'h00AA, 5);
    flush = 1'b1;
    drive(1'b1, 16'hDEAD);
    flush = 1'b0;
    push_seq(16'h0100, 16);
    vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL flush_valid: got %0b want 1", frame_valid); end
    vectors++; if (frame_d !== build(16'h0100)) begin miscompares++; $display("FAIL flush_data: got %h want %h", frame_d, build(16'h0100)); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL flush_ovf: got %0b want 0", ovf); end
    push_seq(16'h0500, 3);
    flush = 1'b1;
    drive(1'b0, 16'h0000);
    flush = 1'b0;
    vectors++; if (frame_d !== build(16'h0100)) begin miscompares++; $display("FAIL flush_full_kept: got %h want %h", frame_d, build(16'h0100)); end
    push_seq(16'h0600, 16);
    frame_ready = 1'b1;
    drive(1'b0, 16'h0000);
    frame_ready = 1'b0;
    vectors++; if (frame_d !== build(16'h0600)) begin miscompares++; $display("FAIL flush_restart: got %h want %h", frame_d, build(16'h0600)); end
    vectors++; if (frame_cnt !== 8'd1) begin miscompares++; $display("FAIL flush_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_gaps();
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 16'h0200 + 16'(k));
      if (k < 15) begin
        for (int g = 0; g < (k % 3) + (k == 14 ? 1 : 0); g++) begin
          drive(1'b0, 16'hFFFF);
        end
      end
      if (k == 14) begin
        vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL gaps_early: got %0b want 0", frame_valid); end
      end
    end
    vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL gaps_valid: got %0b want 1", frame_valid); end
    vectors++; if (frame_d !== build(16'h0200)) begin miscompares++; $display("FAIL gaps_data: got %h want %h", frame_d, build(16'h0200)); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    push_seq(16'h0001, 32);
    frame_ready = 1'b1;
    drive(1'b1, 16'h0055);
    frame_ready = 1'b0;
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL simul_drop_ovf: got %0b want 1", ovf); end
    vectors++; if (frame_cnt !== 8'd1) begin miscompares++; $display("FAIL simul_hs_cnt: got %0d want 1", frame_cnt); end
    vectors++; if (frame_d !== build(16'h0011)) begin miscompares++; $display("FAIL simul_next_data: got %h want %h", frame_d, build(16'h0011)); end
    push_seq(16'h0400, 15);
    frame_ready = 1'b1;
    drive(1'b1, 16'h040F);
    frame_ready = 1'b0;
    vectors++; if (frame_cnt !== 8'd2) begin miscompares++; $display("FAIL simul_both_cnt: got %0d want 2", frame_cnt); end
    vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL simul_both_valid: got %0b want 1", frame_valid); end
    vectors++; if (frame_d !== build(16'h0400)) begin miscompares++; $display("FAIL simul_both_data: got %h want %h", frame_d, build(16'h0400)); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    push_seq(16'h0001, 32);
    drive(1'b1, 16'h0077);
    frame_ready = 1'b1;
    drive(1'b0, 16'h0000);
    frame_ready = 1'b0;
    push_seq(16'h0700, 7);
    vectors++; if (frame_cnt !== 8'd1 || ovf !== 1'b1 || frame_valid !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_setup: got cnt=%0d ovf=%0b valid=%0b want 1 1 1", frame_cnt, ovf, frame_valid);
    end
    #2 rst = 1'b1;
    #1;
    vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %0b want 0", frame_valid); end
    vectors++; if (frame_d !== 256'd0) begin miscompares++; $display("FAIL rstmid_data: got %h want 0", frame_d); end
    vectors++; if (frame_cnt !== 8'd0) begin miscompares++; $display("FAIL rstmid_cnt: got %0d want 0", frame_cnt); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL rstmid_ovf: got %0b want 0", ovf); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_seq(16'h0300, 15);
    vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_partial: got %0b want 0", frame_valid); end
    drive(1'b1, 16'h030F);
    in_valid = 1'b0;
    vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL rstmid_clean_valid: got %0b want 1", frame_valid); end
    vectors++; if (frame_d !== build(16'h0300)) begin miscompares++; $display("FAIL rstmid_clean_data: got %h want %h", frame_d, build(16'h0300)); end
  endtask

  task automatic test_slot_order();
    logic [15:0] exp1, exp3, exp8, exp15;
`ifdef S2P_BITREV_EN
    exp1 = 16'd8; exp3 = 16'd12; exp8 = 16'd1; exp15 = 16'd15;
`else
    exp1 = 16'd1; exp3 = 16'd3;  exp8 = 16'd8; exp15 = 16'd15;
`endif
    apply_reset();
    push_seq(16'h0000, 16);
    vectors++; if (slot_of(frame_d, 1) !== exp1) begin miscompares++; $display("FAIL order_slot1: got %0d want %0d", slot_of(frame_d, 1), exp1); end
    vectors++; if (slot_of(frame_d, 3) !== exp3) begin miscompares++; $display("FAIL order_slot3: got %0d want %0d", slot_of(frame_d, 3), exp3); end
    vectors++; if (slot_of(frame_d, 8) !== exp8) begin miscompares++; $display("FAIL order_slot8: got %0d want %0d", slot_of(frame_d, 8), exp8); end
    vectors++; if (slot_of(frame_d, 15) !== exp15) begin miscompares++; $display("FAIL order_slot15: got %0d want %0d", slot_of(frame_d, 15), exp15); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; in_valid = 1'b0; in_d = '0; flush = 1'b0; frame_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_flush();
    test_gaps();
    test_simultaneous();
    test_reset_mid();
    test_slot_order();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
